// File: rtl/split_serial_if.sv
// Handshake bundle for split_serial: word input, parallel copy, and the serial stream.
interface split_serial_if #(
  parameter int unsigned WIDTH = 7
);
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] split;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_word, in_valid, ser_ready,
    input  in_ready, split, ser_bit, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_word, in_valid, ser_ready,
    output in_ready, split, ser_bit, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/split_serial.sv
// Word splitter: registered parallel copy plus a valid/ready serial stream of the same word.
// Optional even-parity trailer bit enabled by defining SPLIT_SERIAL_PARITY_EN.
module split_serial #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MSB_FIRST = 0
) (
  input logic          clk,
  input logic          rst,
  split_serial_if.slave bus
);

`ifdef SPLIT_SERIAL_PARITY_EN
  localparam int unsigned NBits = WIDTH + 1;
`else
  localparam int unsigned NBits = WIDTH;
`endif
  localparam int unsigned     IdxW    = $clog2(WIDTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBits - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] split_q;
  logic [IdxW-1:0]  idx_q;
  logic             ser_bit_q;
  logic             ser_valid_q;
  logic             ser_last_q;
`ifdef SPLIT_SERIAL_PARITY_EN
  logic             par_q;
`endif

  logic [WIDTH-1:0] sreg_nxt;
  logic [IdxW-1:0]  idx_nxt;
  logic             nxt_bit;

  // The outgoing bit always sits at the shift-out end of sreg_q.
  always_comb begin
    sreg_nxt = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
    idx_nxt  = idx_q + 1'b1;
    nxt_bit  = (MSB_FIRST != 0) ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
`ifdef SPLIT_SERIAL_PARITY_EN
    if (idx_q == IdxW'(WIDTH - 1)) begin
      nxt_bit = par_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      split_q     <= '0;
      idx_q       <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef SPLIT_SERIAL_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            split_q     <= bus.in_word;
            sreg_q      <= bus.in_word;
            idx_q       <= '0;
            ser_valid_q <= 1'b1;
            ser_bit_q   <= (MSB_FIRST != 0) ? bus.in_word[WIDTH-1] : bus.in_word[0];
            ser_last_q  <= 1'b0;
`ifdef SPLIT_SERIAL_PARITY_EN
            par_q       <= ^bus.in_word;
`endif
            state_q     <= StShift;
          end
        end
        StShift: begin
          if (bus.ser_ready) begin
            if (idx_q == LastIdx) begin
              state_q     <= StIdle;
              ser_valid_q <= 1'b0;
              ser_last_q  <= 1'b0;
              ser_bit_q   <= 1'b0;
            end else begin
              idx_q      <= idx_nxt;
              sreg_q     <= sreg_nxt;
              ser_bit_q  <= nxt_bit;
              ser_last_q <= (idx_nxt == LastIdx);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.split     = split_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = ser_valid_q;

endmodule

// File: tb/tb_split_serial.sv
// Bench for split_serial: LSB-first and MSB-first instances share stimulus and are checked
// every cycle against a word/bit-list model, plus literal checks from hand-worked words.
module tb_split_serial;
  localparam int W = 7;
`ifdef SPLIT_SERIAL_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] in_word;
  logic         in_valid;
  logic         ser_ready;

  split_serial_if #(.WIDTH(W)) if_l ();
  split_serial_if #(.WIDTH(W)) if_m ();

  assign if_l.in_word   = in_word;
  assign if_l.in_valid  = in_valid;
  assign if_l.ser_ready = ser_ready;
  assign if_m.in_word   = in_word;
  assign if_m.in_valid  = in_valid;
  assign if_m.ser_ready = ser_ready;

  split_serial #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));
  split_serial #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(if_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a transfer is just the list of bits the word must produce, walked one per handshake.
  bit           m_busy;
  int           m_idx;
  logic [W-1:0] m_split;
  bit           m_lsb[NB];
  bit           m_msb[NB];
  int           acc_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_idx   = 0;
      m_split = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_split = in_word;
        for (int k = 0; k < W; k++) begin
          m_lsb[k] = in_word[k];
          m_msb[k] = in_word[W-1-k];
        end
`ifdef SPLIT_SERIAL_PARITY_EN
        m_lsb[W] = ^in_word;
        m_msb[W] = ^in_word;
`endif
        m_idx  = 0;
        m_busy = 1'b1;
        acc_cnt++;
      end
    end else if (ser_ready) begin
      if (m_idx == NB - 1) m_busy = 1'b0;
      else m_idx++;
    end
  end

  always @(negedge clk) begin
    chk("in_ready_l", if_l.in_ready, !m_busy);
    chk("in_ready_m", if_m.in_ready, !m_busy);
    chk("ser_valid_l", if_l.ser_valid, m_busy);
    chk("ser_valid_m", if_m.ser_valid, m_busy);
    chk("busy_l", if_l.busy, m_busy);
    chk("busy_m", if_m.busy, m_busy);
    chk("split_l", if_l.split, m_split);
    chk("split_m", if_m.split, m_split);
    if (m_busy) begin
      chk("ser_bit_l", if_l.ser_bit, m_lsb[m_idx]);
      chk("ser_bit_m", if_m.ser_bit, m_msb[m_idx]);
      chk("ser_last_l", if_l.ser_last, m_idx == NB - 1);
      chk("ser_last_m", if_m.ser_last, m_idx == NB - 1);
    end
  end

  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Hand-worked sequences for 7'h59 (parity of 7'h59 is 0).
  int lsb_seq[8] = '{1, 0, 0, 1, 1, 0, 1, 0};
  int msb_seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  initial begin
    int last_acc;
    bit got;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    ser_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_split", if_l.split, 0);
    chk("rst_ser_valid", if_l.ser_valid, 0);
    chk("rst_ser_last", if_l.ser_last, 0);
    chk("rst_ser_bit", if_l.ser_bit, 0);
    chk("rst_in_ready", if_l.in_ready, 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_split", if_l.split, 0);
    chk("idle_in_ready", if_m.in_ready, 1);

    // Basic load, both bit orders.
    send(7'h59);
    chk("load_split", if_l.split, 7'h59);
    for (int k = 0; k < NB; k++) begin
      chk("seq_lsb", if_l.ser_bit, lsb_seq[k]);
      chk("seq_msb", if_m.ser_bit, msb_seq[k]);
      chk("seq_last", if_l.ser_last, k == NB - 1);
      chk("seq_inrdy", if_l.in_ready, 0);
      @(negedge clk);
    end
    chk("done_in_ready", if_l.in_ready, 1);

    // Backpressure on bit 2.
    @(negedge clk);
    send(7'h59);
    repeat (2) @(negedge clk);
    ser_ready = 1'b0;
    repeat (3) begin
      chk("bp_bit_l", if_l.ser_bit, lsb_seq[2]);
      chk("bp_bit_m", if_m.ser_bit, msb_seq[2]);
      chk("bp_last", if_l.ser_last, 0);
      chk("bp_split", if_l.split, 7'h59);
      @(negedge clk);
    end
    ser_ready = 1'b1;
    for (int k = 2; k < NB; k++) begin
      chk("bp_seq_lsb", if_l.ser_bit, lsb_seq[k]);
      chk("bp_seq_msb", if_m.ser_bit, msb_seq[k]);
      chk("bp_split", if_l.split, 7'h59);
      @(negedge clk);
    end

    // Overlap: new word presented while busy must wait for in_ready.
    send(7'h13);
    in_valid = 1'b1;
    in_word  = 7'h2A;
    last_acc = acc_cnt;
    got      = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (acc_cnt != last_acc) got = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL overlap_accept: word never accepted within 40 cycles");
    end
    chk("overlap_split", if_l.split, 7'h2A);
    chk("overlap_bit0_l", if_l.ser_bit, 0);
    repeat (NB) @(negedge clk);

    // Abort with reset after bit 3 has transferred.
    @(negedge clk);
    send(7'h55);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_valid_l", if_l.ser_valid, 0);
    chk("abort_valid_m", if_m.ser_valid, 0);
    chk("abort_split", if_l.split, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", if_l.ser_valid, 0);

`ifdef SPLIT_SERIAL_PARITY_EN
    send(7'h01);
    repeat (NB - 1) @(negedge clk);
    chk("par01_bit_l", if_l.ser_bit, 1);
    chk("par01_bit_m", if_m.ser_bit, 1);
    chk("par01_last", if_l.ser_last, 1);
    @(negedge clk);
`endif

    // Randomized traffic with a holding upstream and random backpressure.
    last_acc = acc_cnt;
    for (int c = 0; c < 500; c++) begin
      if (!in_valid || acc_cnt != last_acc) begin
        last_acc = acc_cnt;
        in_valid = ($urandom_range(0, 2) != 0);
        in_word  = W'($urandom);
      end
      ser_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    repeat (NB + 2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
